led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Registered controller that drives the board's ten discrete LEDs (oLed0–oLed9) through selectable animated patterns: static, chase, bounce and blink. It replaces the fixed per-pin constant assignments at the top level. Pattern and mode come from slide switches, and run/step control comes from push-buttons. All pattern steps are paced by an internal prescaled tick.

## Interface
- TICK_DIV, default 12_500_000: clocks per pattern step (4 steps/s at 50 MHz). Minimum 2.
- LED_N, default 10: number of LEDs. Fixed at 10 for this board; present for package consistency only.
- iClk  in  1  system clock, 50 MHz on board.
- iRst_n  in  1  synchronous, active-low reset, sampled on the iClk rising edge.
- iMode  in  2  pattern mode: 00 STATIC, 01 CHASE, 10 BOUNCE, 11 BLINK.
- iPattern  in  10  user pattern. Used by STATIC and BLINK. Bit k maps to oLed k.
- iRun  in  1  level: 1 = free-run on ticks, 0 = paused.
- iStep  in  1  push-button, already debounced. A rising edge advances one step while paused.
- oLed0 … oLed9  out  1 each  LED drive, 1 = lit, registered.
- oTick  out  1  one-cycle pulse on every step taken, free-run or single-step. For test/observation.

## Operation
- State machine: LOAD, RUN, PAUSE.
  - LOAD lasts one cycle and initialises the mode's pattern. Next state is RUN if iRun=1, otherwise PAUSE.
  - RUN goes to PAUSE when iRun=0.
  - PAUSE goes to RUN when iRun=1.
  - From any state, a change of iMode versus the registered mode goes to LOAD on the next cycle. The registered mode updates in the same cycle.
- Internal registers:
  - pos: 4-bit, range 0–9.
  - dir: 1 = up.
  - blink_ph: 1 bit.
  - prescaler: ceil(log2(TICK_DIV)) bits.
  - iStep delay flop, for edge detection.
- LOAD initialisation: pos=0, dir=up, blink_ph=1, prescaler=0.
- Step event:
  - In RUN: prescaler reaches TICK_DIV-1. Prescaler then wraps to 0.
  - In PAUSE: rising edge of iStep. The prescaler holds its value while paused.
  - In LOAD: iStep is ignored.
- Per-step update, by mode:
  - STATIC: no state change.
  - CHASE: pos = (pos==9) ? 0 : pos+1.
  - BOUNCE, going up: pos+1. At pos==8 the step lands on 9 and sets dir=down.
  - BOUNCE, going down: pos-1. At pos==1 the step lands on 0 and sets dir=up. The ends are therefore never repeated: the sequence is 0,1,…,9,8,…,0,1.
  - BLINK: blink_ph toggles.
- LED output, registered every cycle from the next-state values:
  - STATIC: iPattern. Live input, follows it with 1-cycle latency.
  - CHASE/BOUNCE: one-hot, bit pos.
  - BLINK: iPattern when blink_ph=1, else all zero.
- Reset state:
  - All oLed=0, oTick=0, state=LOAD.
  - Registered mode=STATIC, pos=0, dir=up, blink_ph=1, prescaler=0, step-edge flop=0.
- Reset mid-operation takes priority over everything and behaves identically to power-up.

## Timing
- Reset: outputs are 0 on the first edge with iRst_n=0. They are held while iRst_n=0.
- After release, LOAD occupies the first cycle. LEDs show the mode's initial pattern on the following edge.
- RUN step period: exactly TICK_DIV cycles, measured from LOAD exit.
- oTick asserts in the step cycle. LEDs show the new pattern on the same edge as oTick is registered (1-cycle latency from the step condition).
- Single-step: the iStep rise is seen at edge n and oTick is high after edge n+1. A held iStep produces one step only.
- iRun rising while paused: the prescaler resumes from its held value, with no extra tick.
- Same-cycle step and mode change: the mode change wins. LOAD runs and the step is discarded.
- Same-cycle iStep edge and iRun=1: the state goes to RUN and the step edge is ignored.

## Structure
- Package led_seq_pkg holds:
  - the mode enum: MODE_STATIC, MODE_CHASE, MODE_BOUNCE, MODE_BLINK;
  - the state enum: ST_LOAD, ST_RUN, ST_PAUSE;
  - the LED_N=10 constant;
  - a one-hot decode function for pos.
- One sub-module, led_tick_gen: the prescaler with enable, clear and terminal-count pulse, parameterised by TICK_DIV.
- The top holds the FSM, step logic and output registers.

## Test plan
All scenarios run with TICK_DIV=4.
- Reset, then CHASE, iRun=1 → oLed one-hot at 0, then 1, 2, …, 9, 0. Each advance is exactly 4 cycles apart and is accompanied by an oTick pulse.
- BOUNCE, iRun=1, observe 20 steps → positions 0,1,…,9,8,…,0,1. No repeated endpoint.
- BLINK, iPattern=10'h2A5 → outputs alternate 0x2A5 and 0x000 every 4 cycles, starting with 0x2A5.
- CHASE, iRun=0, hold iStep high for 10 cycles, then pulse it twice → exactly 3 steps (pos 0→3), 3 oTick pulses, and the prescaler is not advanced.
- In RUN at pos=6, switch iMode to BOUNCE in the same cycle as a tick → LOAD happens, pos=0, and no step is taken. The next step arrives 4 cycles after LOAD.
- Assert iRst_n=0 mid-BLINK for 1 cycle → all LEDs 0 and oTick 0 on the next edge. After release, the STATIC-to-current-mode reload is followed by LOAD.

Source files
------------

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and helpers for the LED pattern sequencer: mode/state enums, LED count, one-hot decode.
// Pure declarations: no logic, no latency, no backpressure.
package led_seq_pkg;

    localparam int LED_N = 10;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    function automatic logic [LED_N-1:0] posOneHot(input logic [3:0] pos);
        logic [LED_N-1:0] v;
        v = '0;
        if (pos <= 4'(LED_N - 1)) begin
            v[pos] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control inputs and LED drive outputs of the sequencer, bundled with master/slave views.
// Wires only: no latency, no backpressure.
interface led_seq_if;
    import led_seq_pkg::*;

    logic [1:0]       iMode;
    logic [LED_N-1:0] iPattern;
    logic             iRun;
    logic             iStep;
    logic             oLed0, oLed1, oLed2, oLed3, oLed4;
    logic             oLed5, oLed6, oLed7, oLed8, oLed9;
    logic             oTick;

    modport master (
        output iMode, iPattern, iRun, iStep,
        input  oLed0, oLed1, oLed2, oLed3, oLed4,
        input  oLed5, oLed6, oLed7, oLed8, oLed9,
        input  oTick
    );

    modport slave (
        input  iMode, iPattern, iRun, iStep,
        output oLed0, oLed1, oLed2, oLed3, oLed4,
        output oLed5, oLed6, oLed7, oLed8, oLed9,
        output oTick
    );

endinterface

// File: rtl/led_pattern_sequencer_tick_gen.sv
// Step prescaler: counts enabled cycles, oTc pulses combinationally on the terminal count, then wraps.
// Latency: oTc is combinational from the count; clear wins over enable; holds when disabled.
module led_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iEn,
    input  logic iClr,
    output logic oTc
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign oTc = iEn && (cnt == LAST);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt <= '0;
        end else if (iClr) begin
            cnt <= '0;
        end else if (iEn) begin
            cnt <= oTc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives ten LEDs through static/chase/bounce/blink patterns, paced by a prescaled tick or single-step button.
// Latency: LEDs and oTick registered, 1 cycle after the step condition; no backpressure.
module led_pattern_sequencer #(
    parameter int TICK_DIV = 12_500_000,
    parameter int LED_N    = 10
) (
    input  logic     iClk,
    input  logic     iRst_n,
    led_seq_if.slave ledBus
);
    import led_seq_pkg::*;

    state_t           state, stateNext;
    mode_t            modeReg, modeIn;
    logic [3:0]       pos, posNext;
    logic             dir, dirNext;
    logic             blinkPh, blinkPhNext;
    logic             stepDly;
    logic             stepNow;
    logic             modeChg;
    logic             presTc;
    logic [LED_N-1:0] ledQ, ledNext;
    logic             tickQ;

    assign modeIn  = mode_t'(ledBus.iMode);
    assign modeChg = (modeIn != modeReg);

    led_tick_gen #(.TICK_DIV(TICK_DIV)) uTickGen (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iEn    (state == ST_RUN),
        .iClr   (state == ST_LOAD),
        .oTc    (presTc)
    );

    always_comb begin
        stateNext   = state;
        posNext     = pos;
        dirNext     = dir;
        blinkPhNext = blinkPh;
        stepNow     = 1'b0;
        ledNext     = '0;

        case (state)
            ST_LOAD: begin
                posNext     = 4'd0;
                dirNext     = 1'b1;
                blinkPhNext = 1'b1;
                stateNext   = ledBus.iRun ? ST_RUN : ST_PAUSE;
            end
            ST_RUN: begin
                stepNow = presTc;
                if (!ledBus.iRun) stateNext = ST_PAUSE;
            end
            ST_PAUSE: begin
                // A resume request in the same cycle swallows the button edge.
                stepNow = ledBus.iStep && !stepDly && !ledBus.iRun;
                if (ledBus.iRun) stateNext = ST_RUN;
            end
            default: stateNext = ST_LOAD;
        endcase

        if (modeChg) begin
            stateNext = ST_LOAD;
            stepNow   = 1'b0;
        end

        if (stepNow) begin
            case (modeReg)
                MODE_CHASE:  posNext = (pos == 4'd9) ? 4'd0 : pos + 4'd1;
                MODE_BOUNCE: begin
                    if (dir) begin
                        posNext = pos + 4'd1;
                        if (pos == 4'd8) dirNext = 1'b0;
                    end else begin
                        posNext = pos - 4'd1;
                        if (pos == 4'd1) dirNext = 1'b1;
                    end
                end
                MODE_BLINK:  blinkPhNext = ~blinkPh;
                default:     ;
            endcase
        end

        case (modeIn)
            MODE_STATIC: ledNext = ledBus.iPattern;
            MODE_BLINK:  ledNext = blinkPhNext ? ledBus.iPattern : '0;
            default:     ledNext = posOneHot(posNext);
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state   <= ST_LOAD;
            modeReg <= MODE_STATIC;
            pos     <= 4'd0;
            dir     <= 1'b1;
            blinkPh <= 1'b1;
            stepDly <= 1'b0;
            ledQ    <= '0;
            tickQ   <= 1'b0;
        end else begin
            state   <= stateNext;
            modeReg <= modeIn;
            pos     <= posNext;
            dir     <= dirNext;
            blinkPh <= blinkPhNext;
            stepDly <= ledBus.iStep;
            ledQ    <= ledNext;
            tickQ   <= stepNow;
        end
    end

    assign ledBus.oLed0 = ledQ[0];
    assign ledBus.oLed1 = ledQ[1];
    assign ledBus.oLed2 = ledQ[2];
    assign ledBus.oLed3 = ledQ[3];
    assign ledBus.oLed4 = ledQ[4];
    assign ledBus.oLed5 = ledQ[5];
    assign ledBus.oLed6 = ledQ[6];
    assign ledBus.oLed7 = ledQ[7];
    assign ledBus.oLed8 = ledQ[8];
    assign ledBus.oLed9 = ledQ[9];
    assign ledBus.oTick = tickQ;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV=4: chase, bounce, blink, single-step,
// mode change on a tick, mid-run reset and live static pattern.
module tb_led_pattern_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    int bseq [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    led_seq_if ledBus ();

    led_pattern_sequencer #(.TICK_DIV(4), .LED_N(10)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .ledBus (ledBus)
    );

    always #5 clk = ~clk;

    logic [9:0] led;
    assign led = {ledBus.oLed9, ledBus.oLed8, ledBus.oLed7, ledBus.oLed6, ledBus.oLed5,
                  ledBus.oLed4, ledBus.oLed3, ledBus.oLed2, ledBus.oLed1, ledBus.oLed0};

    function automatic logic [9:0] oh(input int p);
        logic [9:0] one;
        one = 10'd1;
        return one << p;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    // Three quiet cycles, then a tick carrying the new LED pattern.
    task automatic expectStep(input string tag, input logic [9:0] expLed);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk({tag, " idle"}, {9'b0, ledBus.oTick}, 10'h000);
        end
        cyc(1);
        chk({tag, " tick"}, {9'b0, ledBus.oTick}, 10'h001);
        chk({tag, " led"}, led, expLed);
    endtask

    initial begin
        ledBus.iMode    = 2'b01;
        ledBus.iPattern = 10'h000;
        ledBus.iRun     = 1'b1;
        ledBus.iStep    = 1'b0;

        cyc(2);
        chk("reset led", led, 10'h000);
        chk("reset tick", {9'b0, ledBus.oTick}, 10'h000);

        // Chase: mode reload then LOAD after release, then one-hot walk with wrap.
        rst_n = 1'b1;
        cyc(2);
        chk("chase start led", led, 10'h001);
        chk("chase start tick", {9'b0, ledBus.oTick}, 10'h000);
        for (int k = 1; k <= 10; k++) expectStep("chase", oh(k % 10));

        // Bounce: no repeated endpoints.
        ledBus.iMode = 2'b10;
        cyc(2);
        chk("bounce start led", led, 10'h001);
        for (int i = 1; i < 20; i++) expectStep("bounce", oh(bseq[i]));

        // Blink alternates starting from the pattern.
        ledBus.iPattern = 10'h2A5;
        ledBus.iMode    = 2'b11;
        cyc(2);
        chk("blink start led", led, 10'h2A5);
        for (int i = 0; i < 6; i++) expectStep("blink", (i % 2 == 0) ? 10'h000 : 10'h2A5);

        // Paused chase: a held button steps once, two more pulses step twice.
        ledBus.iMode = 2'b01;
        ledBus.iRun  = 1'b0;
        cyc(2);
        chk("pause start led", led, 10'h001);
        ledBus.iStep = 1'b1;
        cyc(1);
        chk("step1 tick", {9'b0, ledBus.oTick}, 10'h001);
        chk("step1 led", led, 10'h002);
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            chk("step held tick", {9'b0, ledBus.oTick}, 10'h000);
        end
        ledBus.iStep = 1'b0;
        cyc(1);
        chk("step low tick", {9'b0, ledBus.oTick}, 10'h000);
        ledBus.iStep = 1'b1;
        cyc(1);
        chk("step2 tick", {9'b0, ledBus.oTick}, 10'h001);
        chk("step2 led", led, 10'h004);
        ledBus.iStep = 1'b0;
        cyc(1);
        ledBus.iStep = 1'b1;
        cyc(1);
        chk("step3 tick", {9'b0, ledBus.oTick}, 10'h001);
        chk("step3 led", led, 10'h008);
        ledBus.iStep = 1'b0;
        cyc(1);
        chk("step fall tick", {9'b0, ledBus.oTick}, 10'h000);
        chk("step hold led", led, 10'h008);

        // Resume: prescaler was held at zero, so the first tick needs a full period.
        ledBus.iRun = 1'b1;
        cyc(1);
        chk("resume edge tick", {9'b0, ledBus.oTick}, 10'h000);
        expectStep("resume", oh(4));
        expectStep("run", oh(5));
        expectStep("run", oh(6));

        // Mode change lands in the tick cycle: step discarded, LOAD follows.
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("pre-change tick", {9'b0, ledBus.oTick}, 10'h000);
        end
        ledBus.iMode = 2'b10;
        cyc(1);
        chk("change tick", {9'b0, ledBus.oTick}, 10'h000);
        chk("change led", led, 10'h040);
        cyc(1);
        chk("load led", led, 10'h001);
        chk("load tick", {9'b0, ledBus.oTick}, 10'h000);
        expectStep("post-load", oh(1));

        // Reset mid-blink, then reload from STATIC before running.
        ledBus.iPattern = 10'h2A5;
        ledBus.iMode    = 2'b11;
        cyc(2);
        chk("blink2 led", led, 10'h2A5);
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        chk("mid reset led", led, 10'h000);
        chk("mid reset tick", {9'b0, ledBus.oTick}, 10'h000);
        rst_n = 1'b1;
        cyc(1);
        chk("reload tick", {9'b0, ledBus.oTick}, 10'h000);
        cyc(1);
        chk("after reload led", led, 10'h2A5);
        expectStep("blink after reset", 10'h000);

        // Static follows the live pattern with one cycle of latency.
        ledBus.iMode    = 2'b00;
        ledBus.iPattern = 10'h155;
        cyc(2);
        chk("static led", led, 10'h155);
        ledBus.iPattern = 10'h3C3;
        cyc(1);
        chk("static follow led", led, 10'h3C3);
        chk("static tick", {9'b0, ledBus.oTick}, 10'h000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
